pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Multi-cycle sequencer for the NPC program counter. It drives the PC block's adder operands (a, b) and its write enable (wen).
- Each instruction is sequenced as: fetch request to the IFU, wait for the response, hand the instruction to decode/execute, then commit dnpc into pc.
- Resolves redirect priority between sequential, branch, jalr, mret and trap.
- Raises a fetch-fault or misaligned-target trap.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT, 255, maximum cycles spent waiting in S_WAIT before a fetch fault; 0 disables the timeout.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  XLEN  current PC from the PC block.
- dnpc  in  XLEN  PC block adder result (a+b).
- pc_a  out  XLEN  adder operand a.
- pc_b  out  XLEN  adder operand b.
- pc_wen  out  1  PC register write enable.
- ifu_req_valid  out  1  fetch request; address is pc.
- ifu_req_ready  in  1  IFU accepts the request.
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_err  in  1  fetch access error, qualified by ifu_rsp_valid.
- ifu_rsp_inst  in  32  fetched instruction.
- inst  out  32  latched instruction to decode.
- inst_valid  out  1  inst is valid; held high through S_EXEC.
- exe_done  in  1  execute/writeback finished, single-cycle pulse.
- br_taken  in  1  branch taken.
- br_off  in  XLEN  branch/jal offset, relative to pc.
- jalr_en  in  1  jalr.
- jalr_base  in  XLEN  rs1.
- jalr_off  in  XLEN  imm.
- mret_en  in  1  mret.
- mepc  in  XLEN  CSR mepc.
- mtvec  in  XLEN  CSR mtvec.
- trap_en  in  1  ecall/ebreak/illegal raised by execute.
- trap_req  out  1  one-cycle pulse to the CSR unit.
- trap_cause  out  4  0=fetch fault, 1=misaligned target, 2=execute trap.
- minstret  out  CNT_W  retired instruction count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_FETCH.
  - pc_wen=0, ifu_req_valid=0, inst=0, inst_valid=0, trap_req=0, trap_cause=0, minstret=0, wait counter=0.
  - Operand registers: pc_a=0, pc_b=0.
  - The first request is issued in the first cycle after rst rises.
- States: S_FETCH, S_WAIT, S_EXEC, S_UPDATE, S_TRAP.
- S_FETCH:
  - ifu_req_valid=1.
  - The handshake completes in the cycle where valid and ready are both 1; then go to S_WAIT and clear the wait counter.
  - ifu_req_valid stays high until accepted; it is never withdrawn.
- S_WAIT:
  - The wait counter increments every cycle.
  - On ifu_rsp_valid with ifu_rsp_err=0: latch ifu_rsp_inst into inst, set inst_valid=1, go to S_EXEC.
  - On ifu_rsp_valid with ifu_rsp_err=1, or when the counter reaches TIMEOUT (TIMEOUT≠0): trap_cause=0, go to S_TRAP.
  - A response arriving in the same cycle as the timeout is accepted as normal (the response wins).
- S_EXEC:
  - Wait for exe_done.
  - On exe_done, sample the redirect inputs and latch operands by priority:
    - trap_en: trap_cause=2, go to S_TRAP.
    - mret_en: a=mepc, b=0.
    - jalr_en: a=jalr_base, b=jalr_off.
    - br_taken: a=pc, b=br_off.
    - otherwise: a=pc, b=4.
  - If several redirects are asserted together, the highest-priority one wins silently.
  - For every case except trap, go to S_UPDATE.
  - Clear inst_valid on leaving S_EXEC.
- S_UPDATE (one cycle):
  - pc_a/pc_b are stable from registers; dnpc is combinational from them.
  - For jalr, dnpc[0] is ignored in the alignment check.
  - If dnpc[1:0] is aligned (jalr: dnpc[1] only): pc_wen=1, minstret+1, go to S_FETCH.
  - Otherwise: pc_wen=0, trap_cause=1, go to S_TRAP; the instruction is not retired.
- S_TRAP (one cycle):
  - pc_a=mtvec, pc_b=0 are registered on entry.
  - trap_req=1 and pc_wen=1; go to S_FETCH.
  - minstret increments only when trap_cause=2 (the faulting instruction is counted as retired).
  - No alignment check is performed on mtvec.
- pc_wen and trap_req are high for exactly one cycle per commit.
- Outside S_UPDATE and S_TRAP, pc_a and pc_b hold their last values.
- All arithmetic is done by the PC block adder; this block performs no addition except the wait counter and minstret.
- minstret wraps modulo 2^CNT_W.
- Reset asserted mid-operation aborts immediately. An outstanding IFU response arriving after reset must be ignored: S_FETCH ignores ifu_rsp_valid.

Decomposition:
- Shared package npc_pkg:
  - state encoding (5 states, 3 bits);
  - trap_cause constants CAUSE_IFETCH=0, CAUSE_MISALIGN=1, CAUSE_EXEC=2;
  - constant INST_BYTES=4.
- One sub-module, pc_redirect_mux: a combinational priority select that produces {a, b, is_trap, is_jalr} from the redirect inputs. The FSM and counters stay in pc_seq.

Test Plan:
- Reset then sequential flow (pc=0x80000000, ready=1, response 1 cycle later, exe_done 2 cycles later, no redirect) → pc_a=0x80000000, pc_b=4, one pc_wen pulse, minstret=1, next request issued in the following cycle.
- Taken branch with br_off=0xFFFFFFF0 at pc=0x80000010 → pc_a=0x80000010, pc_b=0xFFFFFFF0, pc_wen with dnpc=0x80000000.
- jalr_base=0x80000101, jalr_off=2 (dnpc=0x80000103, bit1 set) → no pc_wen in S_UPDATE, then S_TRAP with trap_cause=1, pc_a=mtvec, trap_req pulse, minstret unchanged.
- trap_en, mret_en and br_taken asserted together → trap wins: trap_cause=2, pc_a=mtvec, minstret+1.
- IFU never responds, TIMEOUT=8 → trap_cause=0 issued 8 cycles after acceptance; ifu_rsp_valid with err=1 gives the same result.
- rst pulled low during S_EXEC, then a stale ifu_rsp_valid arrives after release → all outputs return to reset values, the stale response is ignored, and a fresh request is issued.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC program-counter sequencer.
package npc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT   = 3'd1,
      S_EXEC   = 3'd2,
      S_UPDATE = 3'd3,
      S_TRAP   = 3'd4
   } state_t;

   localparam logic [3:0] CAUSE_IFETCH   = 4'd0;
   localparam logic [3:0] CAUSE_MISALIGN = 4'd1;
   localparam logic [3:0] CAUSE_EXEC     = 4'd2;

   localparam int INST_BYTES = 4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the next-PC adder operands: trap > mret > jalr > branch > sequential.
module pc_redirect_mux
   import npc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            trap_en,
   input  logic            mret_en,
   input  logic            jalr_en,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_off,
   input  logic [XLEN-1:0] jalr_base,
   input  logic [XLEN-1:0] jalr_off,
   input  logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic            is_trap,
   output logic            is_jalr
);

   // Lower-priority requests are dropped silently when a higher one is present.
   // On a trap the operands are don't-care: the sequencer loads mtvec itself.
   always_comb begin
      a       = pc;
      b       = XLEN'(INST_BYTES);
      is_trap = 1'b0;
      is_jalr = 1'b0;
      if (trap_en) begin
         a       = '0;
         b       = '0;
         is_trap = 1'b1;
      end else if (mret_en) begin
         a = mepc;
         b = '0;
      end else if (jalr_en) begin
         a       = jalr_base;
         b       = jalr_off;
         is_jalr = 1'b1;
      end else if (br_taken) begin
         a = pc;
         b = br_off;
      end
   end

endmodule

// File: rtl/pc_seq.sv
// Multi-cycle PC sequencer: fetch, wait, execute, commit dnpc, with trap handling.
module pc_seq
   import npc_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  dnpc,
   output logic [XLEN-1:0]  pc_a,
   output logic [XLEN-1:0]  pc_b,
   output logic             pc_wen,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   input  logic             ifu_rsp_valid,
   input  logic             ifu_rsp_err,
   input  logic [31:0]      ifu_rsp_inst,
   output logic [31:0]      inst,
   output logic             inst_valid,
   input  logic             exe_done,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_off,
   input  logic             jalr_en,
   input  logic [XLEN-1:0]  jalr_base,
   input  logic [XLEN-1:0]  jalr_off,
   input  logic             mret_en,
   input  logic [XLEN-1:0]  mepc,
   input  logic [XLEN-1:0]  mtvec,
   input  logic             trap_en,
   output logic             trap_req,
   output logic [3:0]       trap_cause,
   output logic [CNT_W-1:0] minstret
);

   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t          state, state_nxt;
   logic            armed;
   logic [WCW-1:0]  wait_cnt, wait_nxt;
   logic            is_jalr_q;
   logic            aligned, timeout_hit, retire;
   logic [XLEN-1:0] mx_a, mx_b;
   logic            mx_trap, mx_jalr;
   logic            unused_dnpc;

   pc_redirect_mux #(.XLEN(XLEN)) u_mux (
      .pc        (pc),
      .trap_en   (trap_en),
      .mret_en   (mret_en),
      .jalr_en   (jalr_en),
      .br_taken  (br_taken),
      .br_off    (br_off),
      .jalr_base (jalr_base),
      .jalr_off  (jalr_off),
      .mepc      (mepc),
      .a         (mx_a),
      .b         (mx_b),
      .is_trap   (mx_trap),
      .is_jalr   (mx_jalr)
   );

   // jalr clears bit 0 of its target, so only bit 1 can misalign it.
   assign aligned     = is_jalr_q ? ~dnpc[1] : (dnpc[1:0] == 2'b00);
   assign wait_nxt    = wait_cnt + WCW'(1);
   assign timeout_hit = (TIMEOUT != 0) && (wait_nxt == WCW'(TIMEOUT));
   assign retire      = ((state == S_UPDATE) && aligned) ||
                        ((state == S_TRAP) && (trap_cause == CAUSE_EXEC));
   assign unused_dnpc = ^dnpc[XLEN-1:2];

   // Next-state and the single-cycle strobes.
   always_comb begin
      state_nxt     = state;
      ifu_req_valid = 1'b0;
      pc_wen        = 1'b0;
      trap_req      = 1'b0;
      case (state)
         S_FETCH: begin
            // Held off until the first cycle out of reset; stale responses are ignored here.
            ifu_req_valid = armed;
            if (armed && ifu_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A response in the timeout cycle still wins.
            if (ifu_rsp_valid)    state_nxt = ifu_rsp_err ? S_TRAP : S_EXEC;
            else if (timeout_hit) state_nxt = S_TRAP;
         end
         S_EXEC: begin
            if (exe_done) state_nxt = mx_trap ? S_TRAP : S_UPDATE;
         end
         S_UPDATE: begin
            if (aligned) begin
               pc_wen    = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_TRAP;
            end
         end
         S_TRAP: begin
            trap_req  = 1'b1;
            pc_wen    = 1'b1;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // State register and request arming.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   // Datapath registers: wait counter, instruction latch, trap cause, operands, retire count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt   <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         trap_cause <= CAUSE_IFETCH;
         pc_a       <= '0;
         pc_b       <= '0;
         is_jalr_q  <= 1'b0;
         minstret   <= '0;
      end else begin
         if (state == S_FETCH && ifu_req_valid && ifu_req_ready) wait_cnt <= '0;
         if (state == S_WAIT) wait_cnt <= wait_nxt;

         if (state == S_WAIT && ifu_rsp_valid && !ifu_rsp_err) begin
            inst       <= ifu_rsp_inst;
            inst_valid <= 1'b1;
         end
         if (state == S_EXEC && exe_done) inst_valid <= 1'b0;

         if (state == S_WAIT && (ifu_rsp_valid ? ifu_rsp_err : timeout_hit))
            trap_cause <= CAUSE_IFETCH;
         if (state == S_EXEC && exe_done && mx_trap) trap_cause <= CAUSE_EXEC;
         if (state == S_UPDATE && !aligned) trap_cause <= CAUSE_MISALIGN;

         if (state_nxt == S_TRAP && state != S_TRAP) begin
            pc_a <= mtvec;
            pc_b <= '0;
         end else if (state == S_EXEC && exe_done) begin
            pc_a      <= mx_a;
            pc_b      <= mx_b;
            is_jalr_q <= mx_jalr;
         end

         if (retire) minstret <= minstret + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq with a small PC register model.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_q, dnpc, pc_a, pc_b;
   logic        pc_wen, ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_rsp_inst, inst;
   logic        inst_valid, exe_done, br_taken, jalr_en, mret_en, trap_en, trap_req;
   logic [31:0] br_off, jalr_base, jalr_off, mepc, mtvec;
   logic [3:0]  trap_cause;
   logic [63:0] minstret;
   logic        pc_set_en;
   logic [31:0] pc_set;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   // PC block: adder plus register, with a bench-side override to place the PC.
   assign dnpc = pc_a + pc_b;
   always @(posedge clk or negedge rst) begin
      if (!rst)          pc_q <= 32'h8000_0000;
      else if (pc_set_en) pc_q <= pc_set;
      else if (pc_wen)   pc_q <= dnpc;
   end

   pc_seq #(.XLEN(32), .TIMEOUT(8), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .pc(pc_q), .dnpc(dnpc), .pc_a(pc_a), .pc_b(pc_b), .pc_wen(pc_wen),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_inst(ifu_rsp_inst),
      .inst(inst), .inst_valid(inst_valid), .exe_done(exe_done),
      .br_taken(br_taken), .br_off(br_off), .jalr_en(jalr_en), .jalr_base(jalr_base),
      .jalr_off(jalr_off), .mret_en(mret_en), .mepc(mepc), .mtvec(mtvec), .trap_en(trap_en),
      .trap_req(trap_req), .trap_cause(trap_cause), .minstret(minstret)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (ifu_req_valid !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk(tag, 64'(ifu_req_valid), 64'd1);
   endtask

   task automatic respond(input logic [31:0] w, input logic err);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = err;
      ifu_rsp_inst  = w;
      cyc();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
   endtask

   task automatic exe(input logic t, input logic m, input logic j, input logic b);
      trap_en  = t;
      mret_en  = m;
      jalr_en  = j;
      br_taken = b;
      exe_done = 1'b1;
      cyc();
      exe_done = 1'b0;
      trap_en  = 1'b0;
      mret_en  = 1'b0;
      jalr_en  = 1'b0;
      br_taken = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
      ifu_rsp_inst = '0; exe_done = 1'b0; br_taken = 1'b0; br_off = '0; jalr_en = 1'b0;
      jalr_base = '0; jalr_off = '0; mret_en = 1'b0; mepc = '0; mtvec = 32'h8000_1000;
      trap_en = 1'b0; pc_set_en = 1'b0; pc_set = '0;
      cyc(); cyc();
      chk("rst_req", 64'(ifu_req_valid), 0);
      chk("rst_wen", 64'(pc_wen), 0);
      chk("rst_ivld", 64'(inst_valid), 0);
      chk("rst_inst", 64'(inst), 0);
      chk("rst_trap", 64'(trap_req), 0);
      chk("rst_cause", 64'(trap_cause), 0);
      chk("rst_cnt", minstret, 0);
      chk("rst_a", 64'(pc_a), 0);
      chk("rst_b", 64'(pc_b), 0);

      // Sequential instruction.
      rst = 1'b1; ifu_req_ready = 1'b1;
      cyc();
      chk("first_req", 64'(ifu_req_valid), 1);
      cyc();
      chk("req_drop", 64'(ifu_req_valid), 0);
      respond(32'h0000_0013, 1'b0);
      chk("seq_ivld", 64'(inst_valid), 1);
      chk("seq_inst", 64'(inst), 64'h13);
      cyc();
      exe(0, 0, 0, 0);
      chk("seq_a", 64'(pc_a), 64'h8000_0000);
      chk("seq_b", 64'(pc_b), 4);
      chk("seq_wen", 64'(pc_wen), 1);
      chk("seq_dnpc", 64'(dnpc), 64'h8000_0004);
      chk("seq_ivld_clr", 64'(inst_valid), 0);
      cyc();
      chk("seq_wen_off", 64'(pc_wen), 0);
      chk("seq_cnt", minstret, 1);
      chk("seq_next_req", 64'(ifu_req_valid), 1);

      // Taken backward branch.
      cyc();
      pc_set = 32'h8000_0010; pc_set_en = 1'b1;
      cyc();
      pc_set_en = 1'b0;
      respond(32'h0000_0063, 1'b0);
      br_off = 32'hFFFF_FFF0;
      exe(0, 0, 0, 1);
      chk("br_a", 64'(pc_a), 64'h8000_0010);
      chk("br_b", 64'(pc_b), 64'hFFFF_FFF0);
      chk("br_wen", 64'(pc_wen), 1);
      chk("br_dnpc", 64'(dnpc), 64'h8000_0000);
      cyc();
      chk("br_cnt", minstret, 2);

      // Misaligned jalr target.
      wait_req("jalr_req");
      cyc();
      respond(32'h0000_0067, 1'b0);
      jalr_base = 32'h8000_0101; jalr_off = 32'd2;
      exe(0, 0, 1, 0);
      chk("jalr_a", 64'(pc_a), 64'h8000_0101);
      chk("jalr_wen", 64'(pc_wen), 0);
      chk("jalr_notrap", 64'(trap_req), 0);
      cyc();
      chk("mis_trap", 64'(trap_req), 1);
      chk("mis_cause", 64'(trap_cause), 1);
      chk("mis_a", 64'(pc_a), 64'h8000_1000);
      chk("mis_b", 64'(pc_b), 0);
      chk("mis_wen", 64'(pc_wen), 1);
      cyc();
      chk("mis_trap_off", 64'(trap_req), 0);
      chk("mis_cnt", minstret, 2);

      // Trap beats mret and branch.
      wait_req("etrap_req");
      cyc();
      respond(32'h0000_0073, 1'b0);
      mepc = 32'h8000_0200;
      exe(1, 1, 0, 1);
      chk("etrap_trap", 64'(trap_req), 1);
      chk("etrap_cause", 64'(trap_cause), 2);
      chk("etrap_a", 64'(pc_a), 64'h8000_1000);
      cyc();
      chk("etrap_cnt", minstret, 3);

      // Fetch error response.
      wait_req("ferr_req");
      cyc();
      respond(32'hDEAD_BEEF, 1'b1);
      chk("ferr_trap", 64'(trap_req), 1);
      chk("ferr_cause", 64'(trap_cause), 0);
      chk("ferr_ivld", 64'(inst_valid), 0);
      cyc();
      chk("ferr_cnt", minstret, 3);

      // mret redirect.
      wait_req("mret_req");
      cyc();
      respond(32'h3020_0073, 1'b0);
      exe(0, 1, 1, 1);
      chk("mret_a", 64'(pc_a), 64'h8000_0200);
      chk("mret_b", 64'(pc_b), 0);
      chk("mret_wen", 64'(pc_wen), 1);
      cyc();
      chk("mret_cnt", minstret, 4);

      // Fetch timeout: eight wait cycles after acceptance, then the trap.
      wait_req("to_req");
      for (int i = 0; i < 8; i++) cyc();
      chk("to_early", 64'(trap_req), 0);
      cyc();
      chk("to_trap", 64'(trap_req), 1);
      chk("to_cause", 64'(trap_cause), 0);
      cyc();
      chk("to_cnt", minstret, 4);

      // Reset during execute, stale response afterwards.
      wait_req("rr_req");
      cyc();
      respond(32'h0000_1111, 1'b0);
      chk("rr_exec", 64'(inst_valid), 1);
      #1 rst = 1'b0;
      #1;
      chk("rr_ivld", 64'(inst_valid), 0);
      chk("rr_inst", 64'(inst), 0);
      chk("rr_cnt", minstret, 0);
      chk("rr_a", 64'(pc_a), 0);
      chk("rr_req0", 64'(ifu_req_valid), 0);
      cyc();
      ifu_req_ready = 1'b0;
      rst = 1'b1;
      ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_2222;
      cyc(); cyc();
      ifu_rsp_valid = 1'b0;
      chk("stale_ivld", 64'(inst_valid), 0);
      chk("stale_req", 64'(ifu_req_valid), 1);
      ifu_req_ready = 1'b1;
      cyc();
      respond(32'h0000_3333, 1'b0);
      chk("fresh_inst", 64'(inst), 64'h3333);
      exe(0, 0, 0, 0);
      chk("fresh_a", 64'(pc_a), 64'h8000_0000);
      cyc();
      chk("fresh_cnt", minstret, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
